fp_add_arb: RTL and testbench
=============================

FP_ADD_ARB -- requirements
Module: fp_add_arb

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, where 1 selects round-robin arbitration and 0 selects fixed priority to requester 0.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 13 bits each: operand packed as {sign, exp[3:0], frac[7:0]}.
REQ-007 The block SHALL have ports req0_sub and req1_sub, input, 1 bit each: 1 computes a-b, 0 computes a+b.
REQ-008 The block SHALL have port res, output, 13 bits: the registered result in the same packing as the operands.
REQ-009 The block SHALL have port res_id, output, 1 bit: index of the requester that owns res.
REQ-010 The block SHALL have port res_valid, output, 1 bit: res is valid.
REQ-011 The block SHALL have port res_ready, input, 1 bit: the consumer takes res this cycle.
REQ-012 The block SHALL have port op_cnt, output, 16 bits: count of completed result handshakes.

Function
REQ-013 The block SHALL contain one shared combinational fp add datapath with the following rules:
- sort operands by {exp,frac} magnitude; on equal magnitude, b is treated as larger;
- right-shift the smaller frac by the exponent difference;
- add or subtract the fracs on 9 bits;
- on carry out: exp+1, frac=sum[8:1];
- if the leading-zero count exceeds the larger exp: exp=0, frac=0;
- otherwise left-normalize;
- sign = sign of the larger operand.
REQ-014 When reqN_sub=1, the datapath SHALL use b with its sign bit inverted; exp and frac of b SHALL be unchanged.
REQ-015 The output register SHALL behave as a two-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-016 The accept condition SHALL be acc_en = (state==EMPTY) or (res_ready==1).
REQ-017 At most one requester SHALL be granted per cycle, and reqN_ready SHALL equal acc_en AND (grant==N) AND reqN_valid.
- reqN_ready is combinational from the valids, res_ready and state.
- reqN_ready SHALL NOT depend on the operand values.
REQ-018 Arbitration when only one requester is valid: that requester SHALL be granted.
REQ-019 Arbitration when both requesters are valid:
- RR_EN=1: grant the requester indicated by priority pointer ptr;
- RR_EN=0: always grant requester 0.
REQ-020 On each accepted grant with RR_EN=1, ptr SHALL become the non-granted index; ptr SHALL be unchanged when nothing is granted.
REQ-021 When a request is accepted on edge k:
- res, res_id and res_valid=1 SHALL be visible after edge k;
- latency is 1 cycle;
- sustained throughput is 1 result per cycle while res_ready=1.
REQ-022 Transitions of the FSM:
- EMPTY->FULL on accept;
- FULL->EMPTY on res_ready with no accept;
- FULL->FULL on simultaneous drain and accept, with res replaced by the new result.
REQ-023 In FULL with res_ready=0:
- res and res_id SHALL hold stable;
- both reqN_ready SHALL be 0.
REQ-024 op_cnt SHALL increment on each res_valid AND res_ready, and SHALL saturate at 16'hFFFF.
REQ-025 A requester SHALL hold valid and its operands stable until ready; the block SHALL NOT latch requests that are not accepted.

Reset
REQ-026 While reset=1, regardless of clk:
- res_valid=0;
- res=13'h0000;
- res_id=0;
- ptr=0;
- op_cnt=0;
- state=EMPTY.
REQ-027 A reset asserted mid-operation SHALL discard the held result with no handshake, and reqN_ready SHALL read 0 while reset=1.
REQ-028 The first cycle after reset deassertion SHALL accept requests normally.

Verification
REQ-029 Add test: req0 a={0,1,80h}, b={0,1,80h}, sub=0, res_ready=1 -> next cycle res={0,2,80h}, res_id=0, res_valid=1, op_cnt=1 on the following edge.
REQ-030 Subtract to zero: req1 a=b={0,1,80h}, sub=1 -> res={1,0,00h}, res_id=1.
REQ-031 Round robin: RR_EN=1, both requesters valid for 4 cycles, res_ready=1 -> grants 0,1,0,1, res_id sequence 0,1,0,1, op_cnt=4.
REQ-032 Fixed priority: RR_EN=0, both requesters valid for 3 cycles -> req1_ready stays 0 and all res_id=0.
REQ-033 Backpressure: res_ready=0 for 3 cycles with FULL -> res stable, both ready=0; then res_ready=1 with req0 valid -> drain and accept in the same cycle, res_valid stays 1.
REQ-034 Async reset: assert reset mid-cycle while FULL -> res_valid=0 and op_cnt=0 immediately, before any clk edge.

Source files
------------

// File: rtl/fp_add_arb.sv
// Two-requester arbiter in front of one shared 13-bit {sign,exp[3:0],frac[7:0]} adder.
// The result sits in a single output register guarded by an EMPTY/FULL handshake FSM.
module fp_add_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [12:0] req0_a,
    input  logic [12:0] req0_b,
    input  logic [12:0] req1_a,
    input  logic [12:0] req1_b,
    input  logic        req0_sub,
    input  logic        req1_sub,
    output logic [12:0] res,
    output logic        res_id,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] op_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [12:0] r_res;
    logic        r_res_id;
    logic        r_ptr;
    logic [15:0] r_op_cnt;

    logic        w_grant, w_acc_en, w_acc;
    logic [12:0] w_a, w_b, w_lg, w_sm, w_res;
    logic [3:0]  w_diff, w_lzc, w_exp;
    logic [7:0]  w_shf, w_frac;
    logic [8:0]  w_sum;

    // Arbitration never looks at operand values, only valids, pointer and FSM state.
    assign w_grant    = (req0_valid & req1_valid) ? (RR_EN ? r_ptr : 1'b0) : req1_valid;
    assign w_acc_en   = (r_state == EMPTY) | res_ready;
    assign req0_ready = ~reset & w_acc_en & ~w_grant & req0_valid;
    assign req1_ready = ~reset & w_acc_en &  w_grant & req1_valid;
    assign w_acc      = req0_ready | req1_ready;

    // Shared adder: operands of the granted requester, b's sign flipped for subtract.
    always_comb begin
        w_a    = w_grant ? req1_a : req0_a;
        w_b    = w_grant ? req1_b : req0_b;
        w_b[12] = w_b[12] ^ (w_grant ? req1_sub : req0_sub);
        if (w_b[11:0] >= w_a[11:0]) begin
            w_lg = w_b;
            w_sm = w_a;
        end else begin
            w_lg = w_a;
            w_sm = w_b;
        end
        w_diff = w_lg[11:8] - w_sm[11:8];
        w_shf  = w_sm[7:0] >> w_diff;
        if (w_lg[12] ^ w_sm[12])
            w_sum = {1'b0, w_lg[7:0]} - {1'b0, w_shf};
        else
            w_sum = {1'b0, w_lg[7:0]} + {1'b0, w_shf};
        w_lzc = 4'd8;
        for (int i = 0; i < 8; i++)
            if (w_sum[i]) w_lzc = 4'(7 - i);
        if (w_sum[8]) begin
            w_exp  = w_lg[11:8] + 4'd1;
            w_frac = w_sum[8:1];
        end else if (w_lzc > w_lg[11:8]) begin
            w_exp  = 4'd0;
            w_frac = 8'd0;
        end else begin
            w_exp  = w_lg[11:8] - w_lzc;
            w_frac = w_sum[7:0] << w_lzc;
        end
        w_res = {w_lg[12], w_exp, w_frac};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_acc) w_state_nxt = FULL;
            FULL:    if (res_ready && !w_acc) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res    <= 13'h0000;
            r_res_id <= 1'b0;
            r_ptr    <= 1'b0;
            r_op_cnt <= 16'h0000;
        end else begin
            if (w_acc) begin
                r_res    <= w_res;
                r_res_id <= w_grant;
                if (RR_EN) r_ptr <= ~w_grant;
            end
            if ((r_state == FULL) && res_ready && (r_op_cnt != 16'hFFFF))
                r_op_cnt <= r_op_cnt + 16'd1;
        end
    end

    assign res       = r_res;
    assign res_id    = r_res_id;
    assign res_valid = (r_state == FULL);
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_fp_add_arb.sv
// Directed bench for fp_add_arb: stimulus pushes expected {id,res} into a queue,
// a negedge monitor pops and compares on every result handshake.
module tb_fp_add_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_sub, req1_sub, res_ready;
    logic [12:0] req0_a, req0_b, req1_a, req1_b;

    logic        rr_req0_ready, rr_req1_ready, rr_res_id, rr_res_valid;
    logic [12:0] rr_res;
    logic [15:0] rr_op_cnt;
    logic        fp_req0_ready, fp_req1_ready, fp_res_id, fp_res_valid;
    logic [12:0] fp_res;
    logic [15:0] fp_op_cnt;

    int          n_chk = 0;
    int          n_err = 0;
    logic [13:0] sbq[$];
    logic [13:0] mon_e;

    always #5 clk = ~clk;

    fp_add_arb #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(rr_req0_ready), .req1_ready(rr_req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sub(req0_sub), .req1_sub(req1_sub),
        .res(rr_res), .res_id(rr_res_id), .res_valid(rr_res_valid),
        .res_ready(res_ready), .op_cnt(rr_op_cnt)
    );

    fp_add_arb #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sub(req0_sub), .req1_sub(req1_sub),
        .res(fp_res), .res_id(fp_res_id), .res_valid(fp_res_valid),
        .res_ready(res_ready), .op_cnt(fp_op_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [12:0] a, input logic [12:0] b, input logic sub);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    endtask

    task automatic set1(input logic [12:0] a, input logic [12:0] b, input logic sub);
        req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    endtask

    always @(negedge clk) begin
        if (!reset && rr_res_valid && res_ready) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_unexpected: got res %0h id %0d, expected nothing", rr_res, rr_res_id);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_res", 32'(rr_res), 32'(mon_e[12:0]));
                chk("sb_res_id", 32'(rr_res_id), 32'(mon_e[13]));
            end
        end
    end

    // {a, b, sub, expected result} on requester 0, back to back
    logic [12:0] tv_a[6]   = '{13'h0F80, 13'h04FF, 13'h0280, 13'h0180, 13'h0380, 13'h1180};
    logic [12:0] tv_b[6]   = '{13'h01FF, 13'h0401, 13'h027F, 13'h12A0, 13'h0180, 13'h0180};
    logic        tv_s[6]   = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
    logic [12:0] tv_r[6]   = '{13'h0F80, 13'h0580, 13'h0000, 13'h11C0, 13'h02C0, 13'h0000};

    initial begin
        reset = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 13'h0180; req0_b = 13'h0180; req0_sub = 1'b0;
        req1_a = 13'h0; req1_b = 13'h0; req1_sub = 1'b0;
        #1;
        chk("rst_res_valid", 32'(rr_res_valid), 0);
        chk("rst_res", 32'(rr_res), 0);
        chk("rst_res_id", 32'(rr_res_id), 0);
        chk("rst_op_cnt", 32'(rr_op_cnt), 0);
        chk("rst_ready0", 32'(rr_req0_ready), 0);
        step(); step();
        reset = 1'b0;

        // add {0,1,80}+{0,1,80}
        set0(13'h0180, 13'h0180, 1'b0); res_ready = 1'b1;
        @(negedge clk); chk("add_ready0", 32'(rr_req0_ready), 1); sbq.push_back({1'b0, 13'h0280});
        step(); req0_valid = 1'b0;
        @(negedge clk); chk("add_res_valid", 32'(rr_res_valid), 1);
        step();
        @(negedge clk); chk("add_op_cnt", 32'(rr_op_cnt), 1); chk("add_empty", 32'(rr_res_valid), 0);

        // subtract to zero on requester 1
        step(); set1(13'h0180, 13'h0180, 1'b1);
        @(negedge clk); chk("sub_ready1", 32'(rr_req1_ready), 1); chk("sub_ready0", 32'(rr_req0_ready), 0);
        sbq.push_back({1'b1, 13'h1000});
        step(); req1_valid = 1'b0;
        step();

        // back-to-back datapath vectors
        for (int i = 0; i < 6; i++) begin
            set0(tv_a[i], tv_b[i], tv_s[i]);
            @(negedge clk); chk("vec_ready0", 32'(rr_req0_ready), 1); sbq.push_back({1'b0, tv_r[i]});
            step();
        end
        req0_valid = 1'b0;
        step(); step();

        // round robin vs fixed priority, both valid for 4 cycles
        reset = 1'b1; step(); reset = 1'b0;
        set0(13'h0180, 13'h0180, 1'b0); set1(13'h0280, 13'h0180, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready0", 32'(rr_req0_ready), (i % 2 == 0) ? 1 : 0);
            chk("rr_ready1", 32'(rr_req1_ready), (i % 2 == 1) ? 1 : 0);
            chk("fp_ready1", 32'(fp_req1_ready), 0);
            chk("fp_ready0", 32'(fp_req0_ready), 1);
            if (i > 0) chk("fp_res_id", 32'(fp_res_id), 0);
            sbq.push_back((i % 2 == 0) ? {1'b0, 13'h0280} : {1'b1, 13'h02C0});
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); chk("fp_res_id_last", 32'(fp_res_id), 0);
        step();
        @(negedge clk); chk("rr_op_cnt", 32'(rr_op_cnt), 4); chk("fp_op_cnt", 32'(fp_op_cnt), 4);

        // backpressure: hold FULL for 3 cycles, then drain and accept together
        step(); res_ready = 1'b0; set0(13'h0180, 13'h0180, 1'b0);
        @(negedge clk); chk("bp_ready0_empty", 32'(rr_req0_ready), 1); sbq.push_back({1'b0, 13'h0280});
        step(); set0(13'h0180, 13'h12A0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready0", 32'(rr_req0_ready), 0);
            chk("bp_ready1", 32'(rr_req1_ready), 0);
            chk("bp_res_hold", 32'(rr_res), 32'h0280);
            chk("bp_res_valid", 32'(rr_res_valid), 1);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk); chk("bp_release_ready0", 32'(rr_req0_ready), 1); sbq.push_back({1'b0, 13'h11C0});
        step(); req0_valid = 1'b0;
        @(negedge clk); chk("bp_still_full", 32'(rr_res_valid), 1);
        step();
        @(negedge clk); chk("bp_op_cnt", 32'(rr_op_cnt), 6);

        // async reset while FULL discards the held result
        step(); res_ready = 1'b0; set0(13'h0180, 13'h0180, 1'b0);
        step();
        @(negedge clk); chk("ar_full", 32'(rr_res_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_res_valid", 32'(rr_res_valid), 0);
        chk("ar_op_cnt", 32'(rr_op_cnt), 0);
        chk("ar_res", 32'(rr_res), 0);
        chk("ar_ready0", 32'(rr_req0_ready), 0);
        step(); reset = 1'b0; res_ready = 1'b1;
        @(negedge clk); chk("post_rst_ready0", 32'(rr_req0_ready), 1); sbq.push_back({1'b0, 13'h0280});
        step(); req0_valid = 1'b0;
        step();
        @(negedge clk); chk("post_rst_op_cnt", 32'(rr_op_cnt), 1);
        chk("sb_empty", 32'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
